vrf_pipelined: RTL
==================

// Module: vrf_pipelined
// PURPOSE
//  Next-generation parametrised vector register file for Hydra: N byte-strobed write ports, M read ports.
//  - Read pipeline: registered read data with valid handshake.
//  - Writes: deterministic port priority; collisions detected and counted.
//  - Clear: background sequencer zeroes the whole file without a reset.
//  Sits between vector issue/writeback and the vector lanes.
// PARAMETERS
//  NUM_WR_PORTS  8     number of write ports
//  NUM_RD_PORTS  8     number of read ports
//  NUM_REG       32    number of vector registers (>=2)
//  DATA_SIZE     2048  register width in bits (multiple of 8)
//  CNT_W         16    width of write-conflict counter
//  ADDRESS       localparam $clog2(NUM_REG)
// PORTS
//  clk           in   1                        clock, all state on rising edge
//  arst          in   1                        asynchronous reset, active-high
//  wr_en         in   [NUM_WR_PORTS]           per-port write enable
//  wr_addr       in   [NUM_WR_PORTS][ADDRESS]  write register index
//  wr_data       in   [NUM_WR_PORTS][DATA_SIZE] write data
//  wr_strb       in   [NUM_WR_PORTS][DATA_SIZE/8] byte strobes
//  rd_req        in   [NUM_RD_PORTS]           read request
//  rd_addr       in   [NUM_RD_PORTS][ADDRESS]  read register index
//  rd_valid      out  [NUM_RD_PORTS]           read data valid, 1 cycle after rd_req
//  rd_data       out  [NUM_RD_PORTS][DATA_SIZE] registered read data
//  clr_start     in   1                        start background clear
//  clr_busy      out  1                        clear in progress
//  wr_conflict   out  1                        one-cycle pulse: byte collision seen last cycle
//  conflict_cnt  out  CNT_W                    saturating count of collision cycles
// BEHAVIOUR
//  Reset (arst high, async)
//   - All registers = 0; rd_valid = 0; rd_data = 0; clr_busy = 0.
//   - wr_conflict = 0; conflict_cnt = 0; FSM = IDLE.
//  Write
//   - Byte b of reg r is written at the edge if any port p has wr_en[p], wr_addr[p]==r and wr_strb[p][b].
//   - Winner: lowest-index qualifying port, per byte; other bytes unchanged.
//  Collision
//   - Collision = >=2 qualifying ports on the same byte of the same reg in one cycle.
//   - Next cycle: wr_conflict=1 for exactly one cycle.
//   - conflict_cnt += 1 per colliding cycle, saturating at 2^CNT_W-1.
//   - Same addr with disjoint strobes is NOT a collision.
//  Read
//   - rd_req[r] sampled at edge N; rd_valid[r]=1 and rd_data[r] updated after edge N.
//   - Latency 1 cycle, one result per request per cycle; no backpressure.
//   - rd_req=0: rd_valid=0 next cycle, rd_data holds its last value.
//   - Default: read returns register contents before edge-N writes (read-old).
//  Clear FSM (IDLE, CLEAR)
//   - IDLE -> CLEAR: clr_start=1 at an edge; idx=0.
//   - CLEAR: register idx zeroed each cycle, idx++.
//   - CLEAR -> IDLE: after idx==NUM_REG-1, so clr_busy is high for exactly NUM_REG cycles.
//   - clr_start in CLEAR: ignored.
//   - Write to reg idx in same cycle: clear wins, write dropped (still collision-checked).
//   - Writes to other regs and all reads proceed normally during CLEAR.
//   - arst mid-clear: FSM -> IDLE, all registers 0.
//  Indexing: rd_addr/wr_addr >= NUM_REG (non-pow2 NUM_REG): write ignored, read returns 0.
// CONFIGURATION
//  VRF_BYPASS_EN defined
//   - Read is write-first: rd_data = register merged with edge-N winning write bytes, same reg.
//   - A clear of that reg in the same cycle yields 0.
//  VRF_BYPASS_EN undefined: read-old as above.
// STRUCTURE
//  Package vrf_pkg
//   - Typedefs: vreg_t (DATA_SIZE), vstrb_t (DATA_SIZE/8), vaddr_t (ADDRESS).
//   - clr_state_e {IDLE, CLEAR}.
//  Sub-module vrf_wr_arbiter, one per register
//   - In: all ports' en/addr/data/strb plus its register index.
//   - Out: merged data, byte-enable vector, collision flag.
//   - Top ORs the collision flags, owns the storage, the read pipeline and the clear FSM.
// TESTING
//  1. Port0 writes reg3 0xAA.., strb all-1 -> rd_req reg3 next cycle gives rd_valid=1, data 0xAA.. one cycle later.
//  2. Port2 reg5 data 0x11.. strb 0x0F; port6 reg5 data 0x22.. strb 0xF0 (bytes 0-7)
//     -> bytes 0-3=0x11, 4-7=0x22, wr_conflict stays 0.
//  3. Port1 and port4 both write reg7 byte0 (0x01 vs 0x04) -> byte0=0x01, wr_conflict pulses 1 cycle, conflict_cnt 0->1.
//  4. Fill all regs, pulse clr_start -> clr_busy high 32 cycles; reads of reg0..31 return 0 afterward.
//     Write to reg10 while idx==10 is dropped; write to reg31 while idx==5 is later cleared.
//  5. Write reg9=X and read reg9 same cycle -> old value without VRF_BYPASS_EN, X with it.
//  6. Assert arst mid-clear (idx=12) and with pending rd_req -> all outputs at reset values same cycle, FSM IDLE.

Source files
------------

// File: rtl/vrf_pkg.sv
// Shared types and default sizing for the Hydra vector register file.
package vrf_pkg;

  localparam int unsigned VRF_NUM_REG   = 32;
  localparam int unsigned VRF_DATA_SIZE = 2048;
  localparam int unsigned VRF_ADDR_W    = $clog2(VRF_NUM_REG);

  typedef logic [VRF_DATA_SIZE-1:0]   vreg_t;
  typedef logic [VRF_DATA_SIZE/8-1:0] vstrb_t;
  typedef logic [VRF_ADDR_W-1:0]      vaddr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/vrf_wr_arbiter.sv
// Per-register write merge: lowest-index port wins each byte; flags any byte
// claimed by two or more ports in the same cycle.
module vrf_wr_arbiter
  import vrf_pkg::*;
#(
  parameter int unsigned NUM_WR_PORTS = 8,
  parameter int unsigned DATA_SIZE    = VRF_DATA_SIZE,
  parameter int unsigned ADDRESS      = VRF_ADDR_W
) (
  input  logic [NUM_WR_PORTS-1:0]                  wr_en,
  input  logic [NUM_WR_PORTS-1:0][ADDRESS-1:0]     wr_addr,
  input  logic [NUM_WR_PORTS-1:0][DATA_SIZE-1:0]   wr_data,
  input  logic [NUM_WR_PORTS-1:0][DATA_SIZE/8-1:0] wr_strb,
  input  logic [ADDRESS-1:0]                       reg_idx,
  output logic [DATA_SIZE-1:0]                     merged_data_c,
  output logic [DATA_SIZE/8-1:0]                   byte_en_c,
  output logic                                     collision_c
);

  localparam int unsigned NB = DATA_SIZE / 8;

  logic [NUM_WR_PORTS-1:0] port_hit;
  logic                    seen;

  always_comb begin
    port_hit = '0;
    for (int p = 0; p < NUM_WR_PORTS; p++)
      port_hit[p] = wr_en[p] && (wr_addr[p] == reg_idx);
  end

  // Scan ports in ascending order so the first hit on a byte owns it.
  always_comb begin
    merged_data_c = '0;
    byte_en_c     = '0;
    collision_c   = 1'b0;
    seen          = 1'b0;
    for (int b = 0; b < NB; b++) begin
      seen = 1'b0;
      for (int p = 0; p < NUM_WR_PORTS; p++) begin
        if (port_hit[p] && wr_strb[p][b]) begin
          if (seen) begin
            collision_c = 1'b1;
          end else begin
            seen                   = 1'b1;
            byte_en_c[b]           = 1'b1;
            merged_data_c[b*8 +: 8] = wr_data[p][b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/vrf_pipelined.sv
// Pipelined vector register file: byte-strobed multi-port writes, registered
// reads, collision counting and a background clear. Define VRF_BYPASS_EN for write-first reads.
module vrf_pipelined
  import vrf_pkg::*;
#(
  parameter int unsigned NUM_WR_PORTS = 8,
  parameter int unsigned NUM_RD_PORTS = 8,
  parameter int unsigned NUM_REG      = VRF_NUM_REG,
  parameter int unsigned DATA_SIZE    = VRF_DATA_SIZE,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned ADDRESS     = $clog2(NUM_REG)
) (
  input  logic                                     clk,
  input  logic                                     arst,
  input  logic [NUM_WR_PORTS-1:0]                  wr_en,
  input  logic [NUM_WR_PORTS-1:0][ADDRESS-1:0]     wr_addr,
  input  logic [NUM_WR_PORTS-1:0][DATA_SIZE-1:0]   wr_data,
  input  logic [NUM_WR_PORTS-1:0][DATA_SIZE/8-1:0] wr_strb,
  input  logic [NUM_RD_PORTS-1:0]                  rd_req,
  input  logic [NUM_RD_PORTS-1:0][ADDRESS-1:0]     rd_addr,
  output logic [NUM_RD_PORTS-1:0]                  rd_valid,
  output logic [NUM_RD_PORTS-1:0][DATA_SIZE-1:0]   rd_data,
  input  logic                                     clr_start,
  output logic                                     clr_busy,
  output logic                                     wr_conflict,
  output logic [CNT_W-1:0]                         conflict_cnt
);

  localparam int unsigned NB = DATA_SIZE / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_SIZE-1:0] regs     [NUM_REG];
  logic [DATA_SIZE-1:0] reg_nxt  [NUM_REG];
  logic [DATA_SIZE-1:0] arb_data [NUM_REG];
  logic [NB-1:0]        arb_be   [NUM_REG];
  logic [NUM_REG-1:0]   arb_coll;
  logic [NUM_RD_PORTS-1:0][DATA_SIZE-1:0] rd_src_c;

  clr_state_e         state, state_nxt;
  logic [ADDRESS-1:0] clr_idx, idx_nxt;
  logic               clr_act_c;
  logic               busy_nxt;

  for (genvar r = 0; r < NUM_REG; r++) begin : g_arb
    vrf_wr_arbiter #(
      .NUM_WR_PORTS (NUM_WR_PORTS),
      .DATA_SIZE    (DATA_SIZE),
      .ADDRESS      (ADDRESS)
    ) u_arb (
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_strb       (wr_strb),
      .reg_idx       (ADDRESS'(r)),
      .merged_data_c (arb_data[r]),
      .byte_en_c     (arb_be[r]),
      .collision_c   (arb_coll[r])
    );
  end

  // Clear FSM: state register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      clr_idx  <= '0;
      clr_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_idx  <= idx_nxt;
      clr_busy <= busy_nxt;
    end
  end

  // Clear FSM: next state; clr_start is ignored while clearing
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_start) state_nxt = CLEAR;
      CLEAR:   if (clr_idx == ADDRESS'(NUM_REG - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear FSM: outputs
  always_comb begin
    clr_act_c = (state == CLEAR);
    idx_nxt   = clr_act_c ? clr_idx + ADDRESS'(1) : '0;
    busy_nxt  = (state_nxt == CLEAR);
  end

  // Next register contents; a clear of the same register overrides any write.
  always_comb begin
    for (int r = 0; r < NUM_REG; r++) begin
      reg_nxt[r] = regs[r];
      for (int b = 0; b < NB; b++)
        if (arb_be[r][b]) reg_nxt[r][b*8 +: 8] = arb_data[r][b*8 +: 8];
      if (clr_act_c && (clr_idx == ADDRESS'(r))) reg_nxt[r] = '0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int r = 0; r < NUM_REG; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REG; r++) regs[r] <= reg_nxt[r];
    end
  end

  // Read source: out-of-range indices return zero.
  always_comb begin
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      rd_src_c[p] = '0;
      if (32'(rd_addr[p]) < NUM_REG) begin
`ifdef VRF_BYPASS_EN
        rd_src_c[p] = reg_nxt[rd_addr[p]];
`else
        rd_src_c[p] = regs[rd_addr[p]];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_valid <= '0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      for (int p = 0; p < NUM_RD_PORTS; p++)
        if (rd_req[p]) rd_data[p] <= rd_src_c[p];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_conflict  <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      wr_conflict <= |arb_coll;
      if (|arb_coll && (conflict_cnt != CNT_MAX))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule
